ring_monitor_decoder: RTL and testbench

- Receive-side companion to the 4-bit right-rotating ring counter: samples the ring pattern and decodes the active bit position to a binary index.
- Verifies that every sampled step is a legal single rotate-right, acquires lock, and flags and counts rotation faults.
- Sits on the consumer side of any ring-counter-sequenced datapath. Doubles as a synthesizable checker alongside the assertion binds.

---
 rtl/ring_monitor_decoder.sv | 139 +++++++++++++
 tb/tb_ring_monitor_decoder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ring_monitor_decoder.sv
// Receive-side checker/decoder for a right-rotating one-hot ring counter.
// Tracks legal rotate-right steps, locks after LOCK_CNT of them, and counts faults.
module ring_monitor_decoder #(
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned ERR_W    = 8,
  localparam int unsigned IW      = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     ring_in,
  input  logic             ring_vld,
  output logic [IW-1:0]    idx,
  output logic             idx_vld,
  output logic             locked,
  output logic             lap,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     prev_q, prev_d;
  logic [3:0]       good_q, good_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             idx_vld_q, idx_vld_d;
  logic             lap_q, lap_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic          s_onehot;
  logic          s_legal;
  logic [IW-1:0] s_pos;

  // A power of two has no bits in common with itself minus one.
  assign s_onehot = (ring_in != '0) && ((ring_in & (ring_in - N'(1))) == '0);
  assign s_legal  = (ring_in == {prev_q[0], prev_q[N-1:1]});

  always_comb begin
    s_pos = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ring_in[i]) s_pos = IW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    good_d    = good_q;
    idx_d     = idx_q;
    idx_vld_d = 1'b0;
    lap_d     = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (ring_vld) begin
      unique case (state_q)
        StSearch: begin
          if (s_onehot) begin
            prev_d  = ring_in;
            good_d  = '0;
            state_d = StAcquire;
          end
        end
        StAcquire: begin
          if (s_legal) begin
            prev_d = ring_in;
            good_d = good_q + 4'd1;
            if (good_d == 4'(LOCK_CNT)) begin
              state_d = StLocked;
              idx_d   = s_pos;
            end
          end else if (s_onehot) begin
            prev_d = ring_in;
            good_d = '0;
          end else begin
            prev_d  = '0;
            good_d  = '0;
            state_d = StSearch;
          end
        end
        StLocked: begin
          if (s_legal) begin
            prev_d    = ring_in;
            idx_d     = s_pos;
            idx_vld_d = 1'b1;
            lap_d     = prev_q[0];
          end else begin
            err_d  = 1'b1;
            good_d = '0;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (s_onehot) begin
              prev_d  = ring_in;
              state_d = StAcquire;
            end else begin
              prev_d  = '0;
              state_d = StSearch;
            end
          end
        end
        default: begin
          prev_d  = '0;
          good_d  = '0;
          state_d = StSearch;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StSearch;
      prev_q    <= '0;
      good_q    <= '0;
      idx_q     <= '0;
      idx_vld_q <= 1'b0;
      lap_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      good_q    <= good_d;
      idx_q     <= idx_d;
      idx_vld_q <= idx_vld_d;
      lap_q     <= lap_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign idx     = idx_q;
  assign idx_vld = idx_vld_q;
  assign locked  = (state_q == StLocked);
  assign lap     = lap_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ring_monitor_decoder.sv
// Directed, table-driven bench for ring_monitor_decoder (N=4, LOCK_CNT=2, ERR_W=8).
module tb_ring_monitor_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] ring_in = 4'b0000;
  logic       ring_vld = 1'b0;
  logic [1:0] idx;
  logic       idx_vld, locked, lap, err;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  ring_monitor_decoder #(.N(4), .LOCK_CNT(2), .ERR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ring_in  (ring_in),
    .ring_vld (ring_vld),
    .idx      (idx),
    .idx_vld  (idx_vld),
    .locked   (locked),
    .lap      (lap),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [3:0] ring;
    logic [1:0] idx;
    logic       idx_vld;
    logic       locked;
    logic       lap;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] r);
    ring_vld = v;
    ring_in  = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rotr(input logic [3:0] p);
    return {p[0], p[3:1]};
  endfunction

  initial begin
    logic [3:0] p;
    // vld, ring, idx, idx_vld, locked, lap, err, err_cnt
    vecs.push_back('{1'b1, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}); // SEARCH->ACQUIRE
    vecs.push_back('{1'b1, 4'b1000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}); // lock, no idx_vld
    vecs.push_back('{1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0}); // wrap -> lap
    vecs.push_back('{1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 4'b0100, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1}); // reverse
    vecs.push_back('{1'b1, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1});
    vecs.push_back('{1'b1, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1}); // relock
    vecs.push_back('{1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2}); // zero -> SEARCH
    vecs.push_back('{1'b1, 4'b0110, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2}); // multi-hot
    vecs.push_back('{1'b1, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2});
    vecs.push_back('{1'b1, 4'b1000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2});
    vecs.push_back('{1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2});
    vecs.push_back('{1'b0, 4'b0101, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2}); // strobe low
    vecs.push_back('{1'b0, 4'b1111, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2});
    vecs.push_back('{1'b0, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2});
    vecs.push_back('{1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2}); // resume
    vecs.push_back('{1'b1, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3}); // repeat
    vecs.push_back('{1'b1, 4'b1000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3}); // ACQUIRE restart
    vecs.push_back('{1'b1, 4'b0100, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3});
    vecs.push_back('{1'b1, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3});
    vecs.push_back('{1'b1, 4'b1000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4}); // skip

    #12;
    chk("reset idx", idx, 0);
    chk("reset idx_vld", idx_vld, 0);
    chk("reset locked", locked, 0);
    chk("reset lap", lap, 0);
    chk("reset err", err, 0);
    chk("reset err_cnt", err_cnt, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].vld, vecs[i].ring);
      chk($sformatf("v%0d idx", i), idx, vecs[i].idx);
      chk($sformatf("v%0d idx_vld", i), idx_vld, vecs[i].idx_vld);
      chk($sformatf("v%0d locked", i), locked, vecs[i].locked);
      chk($sformatf("v%0d lap", i), lap, vecs[i].lap);
      chk($sformatf("v%0d err", i), err, vecs[i].err);
      chk($sformatf("v%0d err_cnt", i), err_cnt, vecs[i].cnt);
    end

    // 300 more faults: two legal steps to lock, then a repeated sample.
    p = 4'b1000;
    for (int k = 0; k < 300; k++) begin
      p = rotr(p);
      step(1'b1, p);
      p = rotr(p);
      step(1'b1, p);
      if (k == 0 || k == 299) chk($sformatf("sat%0d locked", k), locked, 1);
      step(1'b1, p);
      if (k == 0 || k == 299) chk($sformatf("sat%0d err", k), err, 1);
      if (k == 100) chk("sat100 err_cnt", err_cnt, 105);
    end
    chk("saturated err_cnt", err_cnt, 255);
    chk("saturated locked", locked, 0);

    // Relock, then pulse reset between edges.
    p = rotr(p);
    step(1'b1, p);
    p = rotr(p);
    step(1'b1, p);
    chk("pre-reset locked", locked, 1);
    chk("pre-reset err_cnt", err_cnt, 255);
    #2;
    rst = 1'b0;
    #1;
    chk("async locked", locked, 0);
    chk("async err_cnt", err_cnt, 0);
    chk("async idx", idx, 0);
    #1;
    rst = 1'b1;
    step(1'b0, 4'b0000);
    chk("post-reset locked", locked, 0);
    chk("post-reset err_cnt", err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
